obi_kernel_launcher: RTL and testbench

OBI_KERNEL_LAUNCHER -- requirements
Module: obi_kernel_launcher

---
 rtl/obi_kernel_launcher.sv | 176 +++++++++++++++++
 tb/tb_obi_kernel_launcher.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/obi_kernel_launcher.sv
// obi_kernel_launcher: programs a thread engine over OBI and polls its status until the kernel finishes
// Ports: launch_* valid/ready request carrying kernel PC, data pointer, block count, group id, in-order flag;
// done_* valid/ready completion with OBI error flag and last status word; busy_o high outside IDLE;
// obi_req_o/obi_rsp_i single-outstanding OBI manager port.
package obi_pkg;
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;
  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } obi_a_chan_t;
  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
  } obi_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  rid;
    logic        err;
  } obi_r_chan_t;
  typedef struct packed {
    obi_r_chan_t r;
    logic        gnt;
    logic        rvalid;
  } obi_rsp_t;
endpackage

module obi_kernel_launcher #(
  parameter int unsigned       PcWidth       = 16,
  parameter int unsigned       AddressWidth  = 32,
  parameter int unsigned       TblockIdxBits = 8,
  parameter int unsigned       TgroupIdBits  = 8,
  parameter obi_pkg::obi_cfg_t ObiCfg        = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t     = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t     = obi_pkg::obi_rsp_t,
  parameter logic [31:0]       BaseAddr      = 32'h0,
  parameter int                PollGap       = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     launch_valid_i,
  output logic                     launch_ready_o,
  input  logic [PcWidth-1:0]       launch_pc_i,
  input  logic [AddressWidth-1:0]  launch_dp_addr_i,
  input  logic [TblockIdxBits-1:0] launch_num_tblocks_i,
  input  logic [TgroupIdBits-1:0]  launch_tgroup_id_i,
  input  logic                     launch_inorder_i,
  output logic                     done_valid_o,
  input  logic                     done_ready_i,
  output logic                     done_err_o,
  output logic [31:0]              done_status_o,
  output logic                     busy_o,
  output obi_req_t                 obi_req_o,
  input  obi_rsp_t                 obi_rsp_i
);
  localparam int unsigned AW = ObiCfg.AddrWidth;
  localparam int unsigned DW = ObiCfg.DataWidth;
  localparam int unsigned GW = PollGap > 1 ? $clog2(PollGap) : 1;
  typedef enum logic [2:0] {IDLE, REQ, RSP, GAP, DONE} state_t;
  state_t                   state_q, state_d;
  logic [2:0]               step_q, step_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic                     err_q, err_d;
  logic [31:0]              status_q, status_d;
  logic [PcWidth-1:0]       pc_q;
  logic [AddressWidth-1:0]  dp_q;
  logic [TblockIdxBits-1:0] nt_q;
  logic [TgroupIdBits-1:0]  tg_q;
  logic                     io_q;
  logic                     accept, is_read, finished;
  logic [AW-1:0]            addr;
  logic [DW-1:0]            wdata;
  logic                     unused_rsp;
  assign unused_rsp     = ^obi_rsp_i;
  assign launch_ready_o = (state_q == IDLE) && !rst_i;
  assign accept         = launch_valid_i && launch_ready_o;
  assign busy_o         = state_q != IDLE;
  assign done_valid_o   = state_q == DONE;
  assign done_err_o     = err_q;
  assign done_status_o  = status_q;
  // Step 5 is the status poll; it reads the same register the start write targets.
  assign is_read  = step_q == 3'd5;
  assign finished = obi_rsp_i.r.rdata[2] && !obi_rsp_i.r.rdata[1];
  assign addr     = AW'(BaseAddr) + AW'({is_read ? 3'd4 : step_q, 2'b00});
  assign wdata    = step_q == 3'd0 ? DW'(pc_q) :
                    step_q == 3'd1 ? DW'(dp_q) :
                    step_q == 3'd2 ? DW'(nt_q) :
                    step_q == 3'd3 ? DW'(tg_q) :
                    step_q == 3'd4 ? DW'(io_q) : '0;
  always_comb begin
    obi_req_o = '0;
    if (state_q == REQ) begin
      obi_req_o.req     = 1'b1;
      obi_req_o.a.addr  = addr;
      obi_req_o.a.we    = !is_read;
      obi_req_o.a.be    = '1;
      obi_req_o.a.wdata = wdata;
    end
  end
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    gap_d    = gap_q;
    err_d    = err_q;
    status_d = status_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d  = REQ;
        step_d   = '0;
        err_d    = 1'b0;
        status_d = '0;
      end
      REQ: state_d = obi_rsp_i.gnt ? RSP : REQ;
      RSP: if (obi_rsp_i.rvalid) begin
        if (obi_rsp_i.r.err) begin
          state_d  = DONE;
          err_d    = 1'b1;
          status_d = is_read ? obi_rsp_i.r.rdata[31:0] : '0;
        end else if (!is_read) begin
          state_d = REQ;
          step_d  = step_q + 3'd1;
        end else begin
          status_d = obi_rsp_i.r.rdata[31:0];
          state_d  = finished ? DONE : (PollGap == 0 ? REQ : GAP);
          gap_d    = '0;
        end
      end
      GAP: begin
        gap_d   = gap_q + GW'(1);
        if (int'(gap_q) == PollGap - 1) begin
          state_d = REQ;
          gap_d   = '0;
        end
      end
      DONE: if (done_ready_i) begin
        state_d = IDLE;
        step_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      step_q   <= '0;
      gap_q    <= '0;
      err_q    <= 1'b0;
      status_q <= '0;
      pc_q     <= '0;
      dp_q     <= '0;
      nt_q     <= '0;
      tg_q     <= '0;
      io_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      gap_q    <= gap_d;
      err_q    <= err_d;
      status_q <= status_d;
      if (accept) begin
        pc_q <= launch_pc_i;
        dp_q <= launch_dp_addr_i;
        nt_q <= launch_num_tblocks_i;
        tg_q <= launch_tgroup_id_i;
        io_q <= launch_inorder_i;
      end
    end
  end
endmodule

// File: tb/tb_obi_kernel_launcher.sv
// tb_obi_kernel_launcher: directed and randomized launches checked against an access-list model
module tb_obi_kernel_launcher;
  localparam logic [31:0] Base = 32'h1000;
  localparam int          Pg   = 4;
  logic              clk, rst;
  logic              launch_valid, launch_ready, launch_inorder;
  logic [15:0]       launch_pc;
  logic [31:0]       launch_dp;
  logic [7:0]        launch_n, launch_id;
  logic              done_valid, done_ready, done_err, busy;
  logic [31:0]       done_status;
  obi_pkg::obi_req_t obi_req;
  obi_pkg::obi_rsp_t obi_rsp;
  int                errors, checks;
  obi_kernel_launcher #(
    .BaseAddr(Base),
    .PollGap(Pg),
    .obi_req_t(obi_pkg::obi_req_t),
    .obi_rsp_t(obi_pkg::obi_rsp_t)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .launch_valid_i(launch_valid),
    .launch_ready_o(launch_ready),
    .launch_pc_i(launch_pc),
    .launch_dp_addr_i(launch_dp),
    .launch_num_tblocks_i(launch_n),
    .launch_tgroup_id_i(launch_id),
    .launch_inorder_i(launch_inorder),
    .done_valid_o(done_valid),
    .done_ready_i(done_ready),
    .done_err_o(done_err),
    .done_status_o(done_status),
    .busy_o(busy),
    .obi_req_o(obi_req),
    .obi_rsp_i(obi_rsp)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [15:0] pc, input logic [31:0] dp, input logic [7:0] n, input logic [7:0] id, input logic io);
    int w = 0;
    while (!launch_ready && w < 20) begin
      tick();
      w++;
    end
    chk("launch_ready", launch_ready, 1);
    launch_valid = 1'b1;
    launch_pc = pc;
    launch_dp = dp;
    launch_n = n;
    launch_id = id;
    launch_inorder = io;
    tick();
    launch_valid = 1'b0;
    launch_pc = 16'($urandom);
    launch_dp = $urandom;
    launch_n = 8'($urandom);
    launch_id = 8'($urandom);
    launch_inorder = 1'($urandom);
    chk("busy_after_launch", busy, 1);
    chk("ready_while_busy", launch_ready, 0);
  endtask
  // One OBI access: expects the request, grants after gd cycles, answers after a random latency.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int gd,
                        input logic [31:0] rdat, input logic e, output int waitc);
    int rd = $urandom_range(0, 2);
    waitc = 0;
    while (!obi_req.req && waitc < 50) begin
      tick();
      waitc++;
    end
    for (int i = 0; i <= gd; i++) begin
      chk("req_held", obi_req.req, 1);
      chk("addr", obi_req.a.addr, addr);
      chk("we", obi_req.a.we, we);
      chk("be", obi_req.a.be, 4'hf);
      chk("aid", obi_req.a.aid, 0);
      if (we) chk("wdata", obi_req.a.wdata, wdata);
      obi_rsp.gnt = i == gd;
      tick();
    end
    obi_rsp.gnt = 1'b0;
    for (int i = 0; i < rd; i++) begin
      chk("req_outstanding", obi_req.req, 0);
      tick();
    end
    chk("req_outstanding", obi_req.req, 0);
    obi_rsp.rvalid = 1'b1;
    obi_rsp.r.rdata = rdat;
    obi_rsp.r.err = e;
    obi_rsp.r.rid = 1'($urandom);
    tick();
    obi_rsp.rvalid = 1'b0;
    obi_rsp.r.err = 1'b0;
    obi_rsp.r.rdata = $urandom;
  endtask
  // Model: five register writes, then status polls until a finished status or the first error.
  task automatic run(input logic [15:0] pc, input logic [31:0] dp, input logic [7:0] n, input logic [7:0] id,
                     input logic io, input int gd, input int err_at, input logic [31:0] sts[$], input int hold);
    logic [31:0] data[5];
    logic [31:0] exp_st = 0;
    logic [31:0] s;
    logic        exp_err = 0;
    logic        fin = 0;
    int          waitc;
    data[0] = 32'(pc);
    data[1] = dp;
    data[2] = 32'(n);
    data[3] = 32'(id);
    data[4] = 32'(io);
    launch(pc, dp, n, id, io);
    for (int i = 0; i < 5 && !fin; i++) begin
      access(1'b1, Base + 32'(4 * i), data[i], gd, $urandom, err_at == i, waitc);
      chk("write_wait", waitc, 0);
      if (err_at == i) begin
        fin = 1;
        exp_err = 1;
      end
    end
    for (int k = 0; k < sts.size() && !fin; k++) begin
      s = sts[k];
      access(1'b0, Base + 32'h10, 32'h0, gd, s, err_at == 5 + k, waitc);
      chk("poll_wait", waitc, k == 0 ? 0 : Pg);
      exp_st = s;
      if (err_at == 5 + k) begin
        fin = 1;
        exp_err = 1;
      end else if (s[2] && !s[1]) fin = 1;
    end
    chk("done_valid", done_valid, 1);
    for (int j = 0; j <= hold; j++) begin
      done_ready = j == hold;
      chk("done_valid_held", done_valid, 1);
      chk("done_err", done_err, exp_err);
      chk("done_status", done_status, exp_st);
      chk("req_in_done", obi_req.req, 0);
      chk("ready_in_done", launch_ready, 0);
      chk("busy_in_done", busy, 1);
      tick();
    end
    done_ready = 1'b0;
    chk("done_cleared", done_valid, 0);
    chk("idle_not_busy", busy, 0);
    chk("ready_after_done", launch_ready, 1);
  endtask
  initial begin
    logic [31:0] sts[$];
    logic [31:0] s;
    int          waitc, np, err_at;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    launch_valid = 1'b0;
    launch_pc = '0;
    launch_dp = '0;
    launch_n = '0;
    launch_id = '0;
    launch_inorder = 1'b0;
    done_ready = 1'b0;
    obi_rsp = '0;
    tick();
    tick();
    chk("rst_ready", launch_ready, 0);
    chk("rst_req", obi_req.req, 0);
    chk("rst_addr", obi_req.a.addr, 0);
    chk("rst_wdata", obi_req.a.wdata, 0);
    chk("rst_we_be", {obi_req.a.we, obi_req.a.be}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {done_valid, done_err}, 0);
    chk("rst_status", done_status, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", launch_ready, 1);
    sts = '{32'h0000_0302, 32'h0300_0034};
    run(16'h40, 32'h8000_0000, 8'd3, 8'd7, 1'b1, 0, -1, sts, 0);
    run(16'h40, 32'h8000_0000, 8'd3, 8'd7, 1'b1, 3, -1, sts, 1);
    run(16'h1234, 32'hdead_beef, 8'd9, 8'd2, 1'b0, 0, 1, sts, 0);
    sts = '{32'h2, 32'h2, 32'h4};
    run(16'h0abc, 32'h0000_1000, 8'd0, 8'd255, 1'b0, 1, -1, sts, 5);
    run(16'h0001, 32'h0000_0002, 8'd4, 8'd1, 1'b1, 0, 6, sts, 2);
    launch(16'h55, 32'h66, 8'd1, 8'd2, 1'b1);
    for (int i = 0; i < 4; i++) access(1'b1, Base + 32'(4 * i), i == 0 ? 32'h55 : i == 1 ? 32'h66 : 32'(i - 1), 0, $urandom, 1'b0, waitc);
    chk("start_req", obi_req.req, 1);
    chk("start_addr", obi_req.a.addr, Base + 32'h10);
    chk("start_wdata", obi_req.a.wdata, 1);
    obi_rsp.gnt = 1'b1;
    tick();
    obi_rsp.gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_req", obi_req.req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", launch_ready, 0);
    tick();
    rst = 1'b0;
    obi_rsp.rvalid = 1'b1;
    obi_rsp.r.rdata = 32'h4;
    tick();
    obi_rsp.rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_rvalid_req", obi_req.req, 0);
      chk("late_rvalid_busy", busy, 0);
      chk("late_rvalid_done", done_valid, 0);
      chk("late_rvalid_ready", launch_ready, 1);
      tick();
    end
    sts = '{32'h0300_0034};
    run(16'h77, 32'h88, 8'd5, 8'd6, 1'b0, 0, -1, sts, 0);
    for (int it = 0; it < 12; it++) begin
      sts = {};
      np = $urandom_range(1, 4);
      for (int k = 0; k < np; k++) begin
        s = $urandom;
        if (k == np - 1) begin
          s[2] = 1'b1;
          s[1] = 1'b0;
        end else if (s[2] && !s[1]) s[1] = 1'b1;
        sts.push_back(s);
      end
      err_at = $urandom_range(0, 9) < 3 ? int'($urandom_range(0, 7)) : -1;
      run(16'($urandom), $urandom, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3), err_at, sts, $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
